reg_file_scoreboard: RTL and testbench

- Parametrised successor to the CPU datapath register file.
- Provides two combinational read ports, one clocked write port and optional write-to-read bypass.
- Supports an optionally hardwired zero register and a debug readout port.
- Adds a per-register pending-write scoreboard so the pipelined control unit can detect RAW hazards and stall issue until writeback.

---
 rtl/reg_file_scoreboard.sv | 118 +++++++++++
 tb/tb_reg_file_scoreboard.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - register file with bypass, zero register and pending-write scoreboard
//
// Ports:
//   clock, reset                       : design clock, asynchronous active-high reset
//   controlRegWrite/writeReg/writeData : writeback port (array updates on rising edge)
//   readReg1/readReg2 -> reg1Data/reg2Data : combinational read ports (optional bypass)
//   useReg1/useReg2                    : current instruction consumes the read port
//   issueValid/issueReg                : issuing instruction will write issueReg (marks pending)
//   reg1Busy/reg2Busy/stall            : RAW hazard indications for the read ports
//   pendingCount                       : number of registers with a pending write
//   inr -> outvalue                    : raw debug readout of the array, never bypassed
module reg_file_scoreboard #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  controlRegWrite,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic [DATA_WIDTH-1:0] reg1Data,
  output logic [DATA_WIDTH-1:0] reg2Data,
  input  logic                  useReg1,
  input  logic                  useReg2,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueReg,
  output logic                  reg1Busy,
  output logic                  reg2Busy,
  output logic                  stall,
  output logic [ADDR_WIDTH:0]   pendingCount,
  input  logic [ADDR_WIDTH-1:0] inr,
  output logic [DATA_WIDTH-1:0] outvalue
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pending;
  logic [DEPTH-1:0]      pending_next;
  logic [DEPTH-1:0]      set_vec;
  logic [DEPTH-1:0]      clr_vec;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   rises;
  logic [ADDR_WIDTH:0]   falls;
  logic                  wr_en;
  logic                  zero1;
  logic                  zero2;
  logic                  hit1;
  logic                  hit2;

  // Writes to the hardwired zero register are dropped entirely.
  assign wr_en = controlRegWrite & ~(ZR & (writeReg == '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[writeReg] <= writeData;
    end
  end

  assign zero1 = ZR & (readReg1 == '0);
  assign zero2 = ZR & (readReg2 == '0);

  // A writeback to the read index this cycle: forwarded data and no hazard.
  assign hit1 = BP & controlRegWrite & (writeReg == readReg1);
  assign hit2 = BP & controlRegWrite & (writeReg == readReg2);

  assign reg1Data = zero1 ? '0 : ((hit1 & wr_en) ? writeData : regs[readReg1]);
  assign reg2Data = zero2 ? '0 : ((hit2 & wr_en) ? writeData : regs[readReg2]);

  assign reg1Busy = ~zero1 & pending[readReg1] & ~hit1;
  assign reg2Busy = ~zero2 & pending[readReg2] & ~hit2;
  assign stall    = (useReg1 & reg1Busy) | (useReg2 & reg2Busy);

  // regs[0] is never written when hardwired, so the raw readout is already 0.
  assign outvalue = regs[inr];

  // Set wins over clear so a re-issue in the writeback cycle keeps the new producer pending.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    rises   = '0;
    falls   = '0;
    if (issueValid && !(ZR && (issueReg == '0))) begin
      set_vec[issueReg] = 1'b1;
    end
    if (controlRegWrite) begin
      clr_vec[writeReg] = 1'b1;
    end
    pending_next = set_vec | (pending & ~clr_vec);
    for (int i = 0; i < DEPTH; i++) begin
      rises = rises + {{ADDR_WIDTH{1'b0}}, (pending_next[i] & ~pending[i])};
      falls = falls + {{ADDR_WIDTH{1'b0}}, (pending[i] & ~pending_next[i])};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
      count_q <= '0;
    end else begin
      pending <= pending_next;
      count_q <= count_q + rises - falls;
    end
  end

  assign pendingCount = count_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - randomized and directed bench for reg_file_scoreboard
module tb_reg_file_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        controlRegWrite;
  logic [4:0]  writeReg;
  logic [15:0] writeData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic        useReg1;
  logic        useReg2;
  logic        issueValid;
  logic [4:0]  issueReg;
  logic [4:0]  inr;

  logic [15:0] b_r1, b_r2, b_out, n_r1, n_r2, n_out;
  logic        b_busy1, b_busy2, b_stall, n_busy1, n_busy2, n_stall;
  logic [5:0]  b_cnt, n_cnt;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic [15:0] m_regs [32];
  bit          m_pend [32];

  always #10 clock = ~clock;

  reg_file_scoreboard u_b (
    .clock(clock), .reset(reset), .controlRegWrite(controlRegWrite),
    .writeReg(writeReg), .writeData(writeData),
    .readReg1(readReg1), .readReg2(readReg2), .reg1Data(b_r1), .reg2Data(b_r2),
    .useReg1(useReg1), .useReg2(useReg2), .issueValid(issueValid), .issueReg(issueReg),
    .reg1Busy(b_busy1), .reg2Busy(b_busy2), .stall(b_stall), .pendingCount(b_cnt),
    .inr(inr), .outvalue(b_out)
  );

  reg_file_scoreboard #(.BYPASS(0)) u_nb (
    .clock(clock), .reset(reset), .controlRegWrite(controlRegWrite),
    .writeReg(writeReg), .writeData(writeData),
    .readReg1(readReg1), .readReg2(readReg2), .reg1Data(n_r1), .reg2Data(n_r2),
    .useReg1(useReg1), .useReg2(useReg2), .issueValid(issueValid), .issueReg(issueReg),
    .reg1Busy(n_busy1), .reg2Busy(n_busy2), .stall(n_stall), .pendingCount(n_cnt),
    .inr(inr), .outvalue(n_out)
  );

  // Reference model: array contents and the set of registers awaiting writeback.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 16'h0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (controlRegWrite && writeReg != 5'd0) m_regs[writeReg] = writeData;
      if (controlRegWrite) m_pend[writeReg] = 1'b0;
      if (issueValid && issueReg != 5'd0) m_pend[issueReg] = 1'b1;
    end
  end

  function automatic logic [15:0] exp_read(input logic [4:0] idx, input bit bp);
    if (idx == 5'd0) return 16'h0;
    if (bp && controlRegWrite && writeReg == idx) return writeData;
    return m_regs[idx];
  endfunction

  function automatic bit exp_busy(input logic [4:0] idx, input bit bp);
    if (idx == 5'd0) return 1'b0;
    return m_pend[idx] && !(bp && controlRegWrite && writeReg == idx);
  endfunction

  function automatic int exp_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("b_reg1Data", 32'(b_r1), 32'(exp_read(readReg1, 1'b1)));
      chk("b_reg2Data", 32'(b_r2), 32'(exp_read(readReg2, 1'b1)));
      chk("b_reg1Busy", 32'(b_busy1), 32'(exp_busy(readReg1, 1'b1)));
      chk("b_reg2Busy", 32'(b_busy2), 32'(exp_busy(readReg2, 1'b1)));
      chk("b_stall", 32'(b_stall),
          32'((useReg1 && exp_busy(readReg1, 1'b1)) || (useReg2 && exp_busy(readReg2, 1'b1))));
      chk("b_pendingCount", 32'(b_cnt), 32'(exp_count()));
      chk("b_outvalue", 32'(b_out), 32'(m_regs[inr]));
      chk("nb_reg1Data", 32'(n_r1), 32'(exp_read(readReg1, 1'b0)));
      chk("nb_reg2Data", 32'(n_r2), 32'(exp_read(readReg2, 1'b0)));
      chk("nb_reg1Busy", 32'(n_busy1), 32'(exp_busy(readReg1, 1'b0)));
      chk("nb_reg2Busy", 32'(n_busy2), 32'(exp_busy(readReg2, 1'b0)));
      chk("nb_stall", 32'(n_stall),
          32'((useReg1 && exp_busy(readReg1, 1'b0)) || (useReg2 && exp_busy(readReg2, 1'b0))));
      chk("nb_pendingCount", 32'(n_cnt), 32'(exp_count()));
      chk("nb_outvalue", 32'(n_out), 32'(m_regs[inr]));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    controlRegWrite = 1'b0; writeReg = '0; writeData = '0;
    readReg1 = '0; readReg2 = '0; useReg1 = 1'b0; useReg2 = 1'b0;
    issueValid = 1'b0; issueReg = '0; inr = '0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [15:0] d);
    controlRegWrite = 1'b1; writeReg = r; writeData = d;
  endtask

  task automatic iss(input logic [4:0] r);
    issueValid = 1'b1; issueReg = r;
  endtask

  function automatic logic [4:0] ra();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    reset = 1'b1;
    idle();
    cmp_en = 1'b1;
    step(); step();
    #2;
    chk("reset_cnt", 32'(b_cnt), 32'd0);
    chk("reset_r1", 32'(b_r1), 32'd0);
    reset = 1'b0;
    step();

    // write reg5, issue reg7, then asynchronous reset mid-cycle
    idle(); wb(5'd5, 16'd16); iss(5'd7); step();
    idle(); readReg1 = 5'd5; inr = 5'd5; readReg2 = 5'd7; useReg2 = 1'b1;
    #2;
    chk("pre_rst_r1", 32'(b_r1), 32'd16);
    chk("pre_rst_busy2", 32'(b_busy2), 32'd1);
    chk("pre_rst_cnt", 32'(b_cnt), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_r1", 32'(b_r1), 32'd0);
    chk("arst_out", 32'(b_out), 32'd0);
    chk("arst_cnt", 32'(b_cnt), 32'd0);
    chk("arst_busy2", 32'(b_busy2), 32'd0);
    chk("arst_stall", 32'(b_stall), 32'd0);
    step();
    reset = 1'b0;

    // write then read; same-cycle bypass on port 2 while debug still shows old value
    idle(); wb(5'd5, 16'd16); step();
    idle(); readReg1 = 5'd5; inr = 5'd5; #2;
    chk("rd_r1", 32'(b_r1), 32'd16);
    chk("rd_out", 32'(b_out), 32'd16);
    wb(5'd11, 16'd24); readReg2 = 5'd11; inr = 5'd11; #1;
    chk("byp_r2", 32'(b_r2), 32'd24);
    chk("byp_out", 32'(b_out), 32'd0);
    chk("nobyp_r2", 32'(n_r2), 32'd0);
    step();
    idle(); inr = 5'd11; #2;
    chk("post_out", 32'(b_out), 32'd24);

    // zero register
    idle(); wb(5'd0, 16'hFFFF); iss(5'd0); readReg1 = 5'd0; #2;
    chk("zero_byp_r1", 32'(b_r1), 32'd0);
    step();
    idle(); #2;
    chk("zero_r1", 32'(b_r1), 32'd0);
    chk("zero_cnt", 32'(b_cnt), 32'd0);

    // RAW hazard on reg3
    idle(); iss(5'd3); step();
    idle(); readReg1 = 5'd3; useReg1 = 1'b1; #2;
    chk("haz_busy1", 32'(b_busy1), 32'd1);
    chk("haz_stall", 32'(b_stall), 32'd1);
    chk("haz_cnt", 32'(b_cnt), 32'd1);
    step();
    wb(5'd3, 16'h00AA); #2;
    chk("wb_busy1", 32'(b_busy1), 32'd0);
    chk("wb_stall", 32'(b_stall), 32'd0);
    chk("wb_r1", 32'(b_r1), 32'h00AA);
    chk("wb_nb_busy1", 32'(n_busy1), 32'd1);
    step();
    idle(); #2;
    chk("wb_cnt", 32'(b_cnt), 32'd0);

    // set and clear in the same cycle on reg4
    idle(); iss(5'd4); step();
    idle(); iss(5'd4); wb(5'd4, 16'd9); step();
    idle(); readReg1 = 5'd4; #2;
    chk("sc_r1", 32'(b_r1), 32'd9);
    chk("sc_busy1", 32'(b_busy1), 32'd1);
    chk("sc_cnt", 32'(b_cnt), 32'd1);
    wb(5'd4, 16'd9); step();

    // counting up and back down
    idle(); iss(5'd1); step();
    idle(); #2 chk("cnt_1", 32'(b_cnt), 32'd1);
    iss(5'd2); step();
    idle(); #2 chk("cnt_2", 32'(b_cnt), 32'd2);
    iss(5'd3); step();
    idle(); #2 chk("cnt_3", 32'(b_cnt), 32'd3);
    wb(5'd2, 16'h1234); readReg2 = 5'd2; useReg2 = 1'b1; #1;
    chk("cnt_nb_busy2", 32'(n_busy2), 32'd1);
    chk("cnt_b_busy2", 32'(b_busy2), 32'd0);
    step();
    idle(); #2 chk("cnt_4", 32'(b_cnt), 32'd2);
    wb(5'd1, 16'h1); step();
    idle(); wb(5'd3, 16'h3); step();

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      controlRegWrite = 1'($urandom_range(0, 1));
      writeReg  = ra();
      writeData = 16'($urandom);
      readReg1  = ra();
      readReg2  = ($urandom_range(0, 3) == 0) ? readReg1 : ra();
      useReg1   = 1'($urandom_range(0, 1));
      useReg2   = 1'($urandom_range(0, 1));
      issueValid = ($urandom_range(0, 2) == 0);
      issueReg  = ra();
      inr       = ra();
      if ($urandom_range(0, 299) == 0) begin
        #4 reset = 1'b1;
        #2 reset = 1'b0;
      end
      step();
    end

    idle();
    step();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
